// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    localparam logic [3:0] ADDR_DATA = 4'h0;
    localparam logic [3:0] ADDR_CTRL = 4'h8;
    localparam logic [3:0] ADDR_STAT = 4'hC;

    localparam logic [3:0] AN_OFF  = 4'hF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low anode pattern for one digit, or all dark when masked.
    function automatic logic [3:0] anode_for(input logic [1:0] dig, input logic masked);
        return masked ? AN_OFF : ~(4'b0001 << dig);
    endfunction

    function automatic logic [6:0] seg_slice(input logic [27:0] frame, input logic [1:0] dig);
        logic [6:0] slice;
        case (dig)
            2'd0:    slice = frame[6:0];
            2'd1:    slice = frame[13:7];
            2'd2:    slice = frame[20:14];
            default: slice = frame[27:21];
        endcase
        return slice;
    endfunction

endpackage

// File: rtl/seg_phase_timer.sv
// Phase counter shared by the BLANK and DRIVE phases: counts 0..term and flags done on term.
module seg_phase_timer #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load_n,
    input  logic [W-1:0] term_n,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] term_q, term_d;

    // load_n latches a new terminal count and restarts the count from zero.
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        term_d = term_q;
        if (load_n) begin
            cnt_d  = '0;
            term_d = term_n;
        end else if (clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            term_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
        end
    end

    assign done = (cnt_q == term_q);

endmodule

// File: rtl/seg_scan_ctrl.sv
// IO-mapped 4-digit 7-segment scan controller with double-buffered frames and inter-digit blanking.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int DIGIT_CYCLES = 16384,
    parameter int BLANK_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  IOAddr,
    input  logic        IOWriteEn,
    input  logic [31:0] IOWriteData,
    output logic [31:0] IOReadData,
    output logic [3:0]  AN,
    output logic [6:0]  LED
);

    localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC);
    localparam logic [CW-1:0] DRIVE_TERM = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_TERM = CW'(BLANK_CYCLES - 1);

    state_t        state_q, state_d;
    logic [1:0]    dig_q, dig_d;
    logic          en_q, en_d;
    logic [3:0]    mask_q, mask_d;
    logic [27:0]   pending_q, pending_d;
    logic          pend_q, pend_d;
    logic [27:0]   shadow_q, shadow_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    led_q, led_d;

    logic          ctrl_wr, data_wr;
    logic          boundary;
    logic          timer_clr, timer_load, phase_done;
    logic [CW-1:0] timer_term;
    logic          unused_wdata;

    assign unused_wdata = ^IOWriteData[31:28];

    always_comb begin
        ctrl_wr = IOWriteEn && (IOAddr == ADDR_CTRL);
        data_wr = IOWriteEn && (IOAddr == ADDR_DATA);
        en_d    = ctrl_wr ? IOWriteData[0]   : en_q;
        mask_d  = ctrl_wr ? IOWriteData[4:1] : mask_q;
    end

    // Uses the post-write enable so clearing en abandons the current phase on the write edge.
    always_comb begin
        state_d    = state_q;
        dig_d      = dig_q;
        boundary   = 1'b0;
        timer_load = 1'b0;
        timer_term = BLANK_TERM;
        case (state_q)
            S_IDLE: begin
                state_d    = S_BLANK;
                dig_d      = 2'd0;
                boundary   = 1'b1;
                timer_load = 1'b1;
            end
            S_BLANK: begin
                if (phase_done) begin
                    state_d    = S_DRIVE;
                    timer_load = 1'b1;
                    timer_term = DRIVE_TERM;
                end
            end
            S_DRIVE: begin
                if (phase_done) begin
                    state_d    = S_BLANK;
                    dig_d      = dig_q + 2'd1;
                    boundary   = (dig_q == 2'd3);
                    timer_load = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!en_d) begin
            state_d    = S_IDLE;
            dig_d      = 2'd0;
            boundary   = 1'b0;
            timer_load = 1'b0;
        end
        timer_clr = (state_d == S_IDLE);
    end

    // A DATA write in the boundary cycle lands after the copy, so it waits a full frame.
    always_comb begin
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        pend_d      = pend_q;
        frame_cnt_d = frame_cnt_q;
        if (boundary) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (pend_q) begin
                shadow_d = pending_q;
                pend_d   = 1'b0;
            end
        end
        if (data_wr) begin
            pending_d = IOWriteData[27:0];
            pend_d    = 1'b1;
        end
    end

    always_comb begin
        an_d  = AN_OFF;
        led_d = SEG_OFF;
        if (state_d == S_DRIVE) begin
            an_d  = anode_for(dig_d, mask_d[dig_d]);
            led_d = ~seg_slice(shadow_d, dig_d);
        end
    end

    always_comb begin
        case (IOAddr)
            ADDR_CTRL: IOReadData = {27'd0, mask_q, en_q};
            ADDR_STAT: IOReadData = {12'd0, (state_q != S_IDLE), dig_q, pend_q, frame_cnt_q};
            default:   IOReadData = 32'd0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            dig_q       <= 2'd0;
            en_q        <= 1'b1;
            mask_q      <= 4'd0;
            pending_q   <= 28'd0;
            pend_q      <= 1'b0;
            shadow_q    <= 28'd0;
            frame_cnt_q <= 16'd0;
            an_q        <= AN_OFF;
            led_q       <= SEG_OFF;
        end else begin
            state_q     <= state_d;
            dig_q       <= dig_d;
            en_q        <= en_d;
            mask_q      <= mask_d;
            pending_q   <= pending_d;
            pend_q      <= pend_d;
            shadow_q    <= shadow_d;
            frame_cnt_q <= frame_cnt_d;
            an_q        <= an_d;
            led_q       <= led_d;
        end
    end

    seg_phase_timer #(
        .W (CW)
    ) u_timer (
        .clk    (CLK),
        .rst_n  (RESET),
        .clr    (timer_clr),
        .load_n (timer_load),
        .term_n (timer_term),
        .done   (phase_done)
    );

    assign AN  = an_q;
    assign LED = led_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized scoreboard bench for seg_scan_ctrl against a frame-position reference model.
module tb_seg_scan_ctrl;

    localparam int DIG        = 8;
    localparam int BLK        = 2;
    localparam int PHASE      = DIG + BLK;
    localparam int FRAME      = 4 * PHASE;
    localparam int NUM_CYCLES = 3000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  io_addr;
    logic        io_we;
    logic [31:0] io_wd;
    logic [31:0] io_rd;
    logic [3:0]  an;
    logic [6:0]  led;

    typedef struct packed {
        logic [3:0]  an;
        logic [6:0]  led;
        logic [31:0] rd;
        logic [3:0]  addr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: the frame is a position 0..FRAME-1 when active.
    bit          m_active;
    int          m_p;
    bit          m_en;
    logic [3:0]  m_mask;
    logic [27:0] m_pending;
    logic [27:0] m_shadow;
    bit          m_pend;
    logic [15:0] m_fc;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .DIGIT_CYCLES (DIG),
        .BLANK_CYCLES (BLK)
    ) dut (
        .CLK         (clk),
        .RESET       (reset_n),
        .IOAddr      (io_addr),
        .IOWriteEn   (io_we),
        .IOWriteData (io_wd),
        .IOReadData  (io_rd),
        .AN          (an),
        .LED         (led)
    );

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic exp_t modelExpect(input logic [3:0] addr);
        exp_t        e;
        int          dig;
        logic [27:0] sh;
        dig    = m_active ? (m_p / PHASE) : 0;
        e.an   = 4'hF;
        e.led  = 7'h7F;
        e.addr = addr;
        if (m_active && ((m_p % PHASE) >= BLK)) begin
            if (!m_mask[dig]) e.an[dig] = 1'b0;
            sh    = m_shadow >> (7 * dig);
            e.led = ~sh[6:0];
        end
        case (addr)
            4'h8:    e.rd = {27'd0, m_mask, m_en};
            4'hC:    e.rd = {12'd0, m_active, 2'(dig), m_pend, m_fc};
            default: e.rd = 32'd0;
        endcase
        return e;
    endfunction

    task automatic modelEdge(input bit rst_n_i, input bit we, input logic [3:0] addr, input logic [31:0] wd);
        bit         new_en;
        logic [3:0] new_mask;
        bit         boundary;
        if (!rst_n_i) begin
            m_active  = 1'b0;
            m_p       = 0;
            m_en      = 1'b1;
            m_mask    = 4'd0;
            m_pending = 28'd0;
            m_shadow  = 28'd0;
            m_pend    = 1'b0;
            m_fc      = 16'd0;
        end else begin
            boundary = 1'b0;
            new_en   = m_en;
            new_mask = m_mask;
            if (we && addr == 4'h8) begin
                new_en   = wd[0];
                new_mask = wd[4:1];
            end
            if (!new_en) begin
                m_active = 1'b0;
                m_p      = 0;
            end else if (!m_active) begin
                m_active = 1'b1;
                m_p      = 0;
                boundary = 1'b1;
            end else begin
                m_p = m_p + 1;
                if (m_p == FRAME) begin
                    m_p      = 0;
                    boundary = 1'b1;
                end
            end
            if (boundary) begin
                if (m_pend) begin
                    m_shadow = m_pending;
                    m_pend   = 1'b0;
                end
                m_fc = m_fc + 16'd1;
            end
            if (we && addr == 4'h0) begin
                m_pending = wd[27:0];
                m_pend    = 1'b1;
            end
            m_en   = new_en;
            m_mask = new_mask;
        end
    endtask

    task automatic applyStimulus(input bit rst_n_i, input bit we, input logic [3:0] addr, input logic [31:0] wd);
        reset_n = rst_n_i;
        io_we   = we;
        io_addr = addr;
        io_wd   = wd;
        sb_q.push_back(modelExpect(addr));
    endtask

    initial begin
        bit          s_rst;
        bit          s_we;
        logic [3:0]  s_addr;
        logic [31:0] s_wd;
        int          r;
        int          k;
        reset_n = 1'b0;
        io_we   = 1'b0;
        io_addr = 4'h0;
        io_wd   = 32'd0;
        modelEdge(1'b0, 1'b0, 4'h0, 32'd0);
        for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
            @(negedge clk);
            s_rst  = 1'b1;
            s_we   = 1'b0;
            s_wd   = $urandom;
            k      = $urandom_range(0, 3);
            s_addr = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'(k * 4);
            if (cyc < 3) begin
                s_rst = 1'b0;
            end else if (cyc < 48) begin
                s_addr = 4'hC;
            end else if (m_active && m_p == FRAME - 1 && $urandom_range(0, 1) == 1) begin
                s_we   = 1'b1;
                s_addr = 4'h0;
            end else begin
                r = $urandom_range(0, 999);
                if (r < 5) begin
                    s_rst = 1'b0;
                end else if (r < 70) begin
                    s_we   = 1'b1;
                    s_addr = 4'h0;
                end else if (r < 95) begin
                    s_we    = 1'b1;
                    s_addr  = 4'h8;
                    s_wd[0] = ($urandom_range(0, 3) != 0);
                end else if (r < 110) begin
                    s_we = 1'b1;
                    k    = $urandom_range(0, 15);
                    s_addr = (k == 0 || k == 8) ? 4'hC : 4'(k);
                end
            end
            applyStimulus(s_rst, s_we, s_addr, s_wd);
            @(posedge clk);
            modelEdge(s_rst, s_we, s_addr, s_wd);
        end
        @(negedge clk);
        #5;
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("AN", 32'(an), 32'(e.an));
                checkOutput("LED", 32'(led), 32'(e.led));
                checkOutput($sformatf("IOReadData[%h]", e.addr), io_rd, e.rd);
            end
        end
    end

endmodule
